audio_capture: RTL

- Record-side counterpart of the ROM-to-codec playback path.
- Drains the audio_codec ADC FIFO through the read/read_ready handshake and mixes left/right into one mono sample.
- Optionally waits for a level trigger, then writes a fixed-length burst of samples into a single-port RAM (rom_lab5-sized, write port).
- Raises done when the burst is complete; the playback path can then replay the RAM.

---
 rtl/audio_capture.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/audio_capture.sv
// Purpose: drain codec ADC FIFO, mix L/R to mono, optionally wait for a level trigger, store a fixed-length burst to RAM.
// Latency: a sample popped at edge t is written (mem_wren/mem_addr/mem_data) during cycle t+1; one sample per cycle sustained.
// Backpressure: none towards the codec; read = read_ready & reset, so the FIFO is drained in every state and unwanted samples are dropped.
module audio_capture #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 24,
  parameter int NUM_SAMPLES = 48000,
  parameter int THRESH      = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              trig_en,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sample_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(NUM_SAMPLES);
  localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W+1)'(1);
  localparam logic [DATA_W-1:0] THRESH_V = DATA_W'(THRESH);
  localparam logic [DATA_W-1:0] MIX_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAG_MAX  = {1'b0, {(DATA_W-1){1'b1}}};

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wren_q, wren_d;

  logic                accept;
  logic [DATA_W-1:0]   mix;
  logic [DATA_W-1:0]   mix_neg;
  logic [DATA_W-1:0]   mag;
  logic                hit;
  logic [ADDR_W:0]     cnt_inc;

  // Pop whenever the codec has data; reset gating keeps the FIFO untouched while held in reset.
  assign read   = read_ready & reset;
  assign accept = read;

  // floor((L+R)/2) == (L>>>1) + (R>>>1) + (L[0] & R[0]); this fits in DATA_W bits without a wider adder.
  assign mix = {readdata_left[DATA_W-1], readdata_left[DATA_W-1:1]}
             + {readdata_right[DATA_W-1], readdata_right[DATA_W-1:1]}
             + {{(DATA_W-1){1'b0}}, readdata_left[0] & readdata_right[0]};

  // Magnitude with the single non-negatable value clamped to the largest positive code.
  assign mix_neg = -mix;
  assign mag     = (mix == MIX_MIN) ? MAG_MAX :
                   (mix[DATA_W-1] ? mix_neg : mix);
  assign hit     = (mag >= THRESH_V);

  assign cnt_inc = cnt_q + ONE_CNT;

  // Next-state and write-port logic; a sample only reaches RAM in ARMED (on trigger) or CAPTURE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        // Samples popped here are discarded, including one arriving with start.
        if (start) begin
          state_d = trig_en ? S_ARMED : S_CAPTURE;
          cnt_d   = '0;
        end
      end
      S_ARMED: begin
        if (accept && hit) begin
          wren_d  = 1'b1;
          addr_d  = '0;
          data_d  = mix;
          cnt_d   = ONE_CNT;
          state_d = (LAST_CNT == ONE_CNT) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (accept) begin
          wren_d = 1'b1;
          addr_d = cnt_q[ADDR_W-1:0];
          data_d = mix;
          cnt_d  = cnt_inc;
          if (cnt_inc == LAST_CNT) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write port and sample counter registers; reset aborts any burst in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      wren_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wren_q <= wren_d;
    end
  end

  assign mem_addr     = addr_q;
  assign mem_data     = data_q;
  assign mem_wren     = wren_q;
  assign sample_count = cnt_q;
  assign busy         = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done         = (state_q == S_DONE);

endmodule
